// File: rtl/blur_ctrl.sv
// blur_ctrl: sequences a 3-phase blur datapath and queues results in a 2-entry FIFO.
// Optional macro BLUR_CTRL_STALL_CNT_EN adds the saturating stall_cnt output.
module blur_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0][7:0] in_pixels,
    output logic            blur_n_rst,
    output logic            blur_en,
    output logic [4:0][7:0] blur_pixels,
    input  logic [7:0]      blur_out_pixel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_pixel,
    output logic            out_eol,
    output logic            out_eof
`ifdef BLUR_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        S1,
        S2,
        S3
    } state_t;

    state_t          r_state;
    logic            r_blur_en;
    logic [4:0][7:0] r_win;
    logic [7:0]      r_pix [2];
    logic [1:0]      r_eol;
    logic [1:0]      r_eof;
    logic            r_wptr;
    logic            r_rptr;
    logic [1:0]      r_occ;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;

    logic            w_busy;
    logic            w_push;
    logic            w_pop;
    logic            w_accept;
    logic [2:0]      w_load;
    logic            w_eol;
    logic            w_eof;

    assign w_busy = (r_state != IDLE);
    assign w_push = (r_state == S3);
    assign w_pop  = out_valid && out_ready;

    // Slots committed once this cycle's pop is taken into account
    assign w_load = {1'b0, r_occ} + {2'b00, w_busy} - {2'b00, w_pop};

    assign in_ready = !rst
                    && ((r_state == IDLE) || (r_state == S3))
                    && (w_load < 3'd2);
    assign w_accept = in_valid && in_ready;

    assign w_eol = (r_col == CW'(WIDTH - 1));
    assign w_eof = w_eol && (r_row == RW'(HEIGHT - 1));

    assign blur_n_rst  = ~rst;
    assign blur_en     = r_blur_en;
    assign blur_pixels = r_win;

    assign out_valid = (r_occ != 2'd0);
    assign out_pixel = out_valid ? r_pix[r_rptr] : 8'd0;
    assign out_eol   = out_valid && r_eol[r_rptr];
    assign out_eof   = out_valid && r_eof[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_blur_en <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state   <= S1;
                        r_blur_en <= 1'b1;
                    end
                end
                S1: begin
                    r_state   <= S2;
                    r_blur_en <= 1'b0;
                end
                S2: begin
                    r_state <= S3;
                end
                S3: begin
                    if (w_accept) begin
                        r_state   <= S1;
                        r_blur_en <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
        end else if (w_accept) begin
            r_win <= in_pixels;
        end
    end

    // Result capture happens in the datapath's third phase (S3)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix[0] <= 8'd0;
            r_pix[1] <= 8'd0;
            r_eol    <= 2'b00;
            r_eof    <= 2'b00;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_pix[r_wptr] <= blur_out_pixel;
                r_eol[r_wptr] <= w_eol;
                r_eof[r_wptr] <= w_eof;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_push) begin
            if (w_eol) begin
                r_col <= '0;
                r_row <= w_eof ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

`ifdef BLUR_CTRL_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= 16'd0;
        end else if (out_valid && !out_ready && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule
